// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage. Issues data-memory requests for
// loads and stores, and forwards load data and ALU results to MEM/WB.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mem_reg_waddr,    EX/MEM destination register
//   mem_we,           EX/MEM register-write enable
//   mem_reg_wdata     EX/MEM ALU result
//   mem_mem_addr      effective byte address
//   mem_aluop         operation code
//   mem_rt_data       store data
//   dm_req .. dm_wdata    data-memory request bus (dm_req is registered)
//   dm_ack, dm_rdata      data-memory completion strobe and read word
//   wb_reg_waddr, wb_we, wb_reg_wdata   results to MEM/WB
//   stallreq_mem      freeze request to the stall controller
//   mem_excp          misaligned access or bus timeout
module mem_stage #(
    parameter int         TIMEOUT = 255,
    parameter logic [7:0] OP_LB   = 8'h20,
    parameter logic [7:0] OP_LH   = 8'h21,
    parameter logic [7:0] OP_LW   = 8'h23,
    parameter logic [7:0] OP_LBU  = 8'h24,
    parameter logic [7:0] OP_LHU  = 8'h25,
    parameter logic [7:0] OP_SB   = 8'h28,
    parameter logic [7:0] OP_SH   = 8'h29,
    parameter logic [7:0] OP_SW   = 8'h2B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_reg_waddr,
    input  logic        mem_we,
    input  logic [31:0] mem_reg_wdata,
    input  logic [31:0] mem_mem_addr,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_rt_data,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [4:0]  wb_reg_waddr,
    output logic        wb_we,
    output logic [31:0] wb_reg_wdata,
    output logic        stallreq_mem,
    output logic        mem_excp
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    state_t        state, state_d;
    logic          req_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          tmo_q, tmo_d;

    logic is_lb, is_lh, is_lw, is_lbu, is_lhu;
    logic is_sb, is_sh, is_sw;
    logic is_load, is_store, is_mem, misaligned;
    logic [1:0]  ofs;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    state_t      cur;

    assign ofs = mem_mem_addr[1:0];

    assign is_lb  = (mem_aluop == OP_LB);
    assign is_lh  = (mem_aluop == OP_LH);
    assign is_lw  = (mem_aluop == OP_LW);
    assign is_lbu = (mem_aluop == OP_LBU);
    assign is_lhu = (mem_aluop == OP_LHU);
    assign is_sb  = (mem_aluop == OP_SB);
    assign is_sh  = (mem_aluop == OP_SH);
    assign is_sw  = (mem_aluop == OP_SW);

    assign is_load  = is_lb | is_lh | is_lw | is_lbu | is_lhu;
    assign is_store = is_sb | is_sh | is_sw;
    assign is_mem   = is_load | is_store;

    assign misaligned = ((is_lh | is_lhu | is_sh) & ofs[0])
                      | ((is_lw | is_sw) & (ofs != 2'b00));

    // Request bus is decoded straight from the held EX/MEM inputs.
    assign dm_we   = is_store;
    assign dm_addr = {mem_mem_addr[31:2], 2'b00};

    always_comb begin
        dm_be    = 4'b1111;
        dm_wdata = mem_rt_data;
        if (is_sb | is_lb | is_lbu) begin
            dm_be = 4'b0001 << ofs;
        end
        if (is_sh | is_lh | is_lhu) begin
            dm_be = 4'b0011 << ofs;
        end
        if (is_sb) begin
            dm_wdata = {4{mem_rt_data[7:0]}};
        end
        if (is_sh) begin
            dm_wdata = {2{mem_rt_data[15:0]}};
        end
    end

    always_comb begin
        unique case (ofs)
            2'd0: ld_byte = rdata_q[7:0];
            2'd1: ld_byte = rdata_q[15:8];
            2'd2: ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half  = ofs[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_val = rdata_q;
        if (is_lb)  load_val = {{24{ld_byte[7]}}, ld_byte};
        if (is_lbu) load_val = {24'b0, ld_byte};
        if (is_lh)  load_val = {{16{ld_half[15]}}, ld_half};
        if (is_lhu) load_val = {16'b0, ld_half};
    end

    // While reset is held the outputs behave as in IDLE.
    assign cur = rst ? IDLE : state;

    always_comb begin
        state_d      = state;
        req_d        = dm_req;
        cnt_d        = cnt;
        rdata_d      = rdata_q;
        tmo_d        = tmo_q;
        wb_reg_waddr = mem_reg_waddr;
        wb_we        = mem_we;
        wb_reg_wdata = mem_reg_wdata;
        stallreq_mem = 1'b0;
        mem_excp     = 1'b0;
        unique case (cur)
            IDLE: begin
                if (is_mem && misaligned) begin
                    mem_excp = 1'b1;
                    wb_we    = 1'b0;
                end else if (is_mem) begin
                    stallreq_mem = 1'b1;
                    wb_we        = 1'b0;
                    state_d      = REQ;
                    req_d        = 1'b1;
                    cnt_d        = '0;
                    tmo_d        = 1'b0;
                end
            end
            REQ: begin
                stallreq_mem = 1'b1;
                wb_we        = 1'b0;
                if (dm_ack) begin
                    rdata_d = dm_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt == CNT_MAX) begin
                    req_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                if (is_load) begin
                    wb_reg_wdata = load_val;
                end
                if (tmo_q) begin
                    mem_excp = 1'b1;
                    wb_we    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dm_req  <= 1'b0;
            cnt     <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state   <= state_d;
            dm_req  <= req_d;
            cnt     <= cnt_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a transaction-level
// model of expected per-cycle outputs and a single compare process.
module tb_mem_stage;

    localparam int         TO = 4;
    localparam logic [7:0] LB  = 8'h20;
    localparam logic [7:0] LH  = 8'h21;
    localparam logic [7:0] LW  = 8'h23;
    localparam logic [7:0] LBU = 8'h24;
    localparam logic [7:0] LHU = 8'h25;
    localparam logic [7:0] SB  = 8'h28;
    localparam logic [7:0] SH  = 8'h29;
    localparam logic [7:0] SW  = 8'h2B;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_reg_waddr;
    logic        mem_we;
    logic [31:0] mem_reg_wdata;
    logic [31:0] mem_mem_addr;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_rt_data;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [4:0]  wb_reg_waddr;
    logic        wb_we;
    logic [31:0] wb_reg_wdata;
    logic        stallreq_mem;
    logic        mem_excp;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_reg_waddr(mem_reg_waddr), .mem_we(mem_we),
        .mem_reg_wdata(mem_reg_wdata), .mem_mem_addr(mem_mem_addr),
        .mem_aluop(mem_aluop), .mem_rt_data(mem_rt_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .wb_reg_waddr(wb_reg_waddr), .wb_we(wb_we),
        .wb_reg_wdata(wb_reg_wdata),
        .stallreq_mem(stallreq_mem), .mem_excp(mem_excp)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic        chk_en = 1'b0;
    logic        e_stall, e_req, e_excp, e_wb, e_done, e_dm, e_st;
    logic [4:0]  e_waddr;
    logic        e_we;
    logic [31:0] e_wdata, e_addr, e_dwdata;
    logic [3:0]  e_be;

    int          req_seen, stall_seen;
    logic [31:0] done_wdata, cap_dwdata;
    logic [3:0]  cap_be;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [7:0] op,
            input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] w;
        w = word >> (8 * int'(addr[1:0]));
        case (op)
            LB:      return 32'($signed(w[7:0]));
            LBU:     return 32'(w[7:0]);
            LH:      return 32'($signed(w[15:0]));
            LHU:     return 32'(w[15:0]);
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] be_model(input logic [7:0] op,
            input logic [1:0] a);
        case (op)
            SB:      return 4'b0001 << a;
            SH:      return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wd_model(input logic [7:0] op,
            input logic [31:0] rt);
        case (op)
            SB:      return {4{rt[7:0]}};
            SH:      return {2{rt[15:0]}};
            default: return rt;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stallreq_mem", 32'(stallreq_mem), 32'(e_stall));
            chk("dm_req", 32'(dm_req), 32'(e_req));
            chk("mem_excp", 32'(mem_excp), 32'(e_excp));
            if (e_wb) begin
                chk("wb_reg_waddr", 32'(wb_reg_waddr), 32'(e_waddr));
                chk("wb_we", 32'(wb_we), 32'(e_we));
                if (!e_excp)
                    chk("wb_reg_wdata", wb_reg_wdata, e_wdata);
            end
            if (e_dm) begin
                chk("dm_we", 32'(dm_we), 32'(e_st));
                chk("dm_addr", dm_addr, e_addr);
                if (e_st) begin
                    chk("dm_be", 32'(dm_be), 32'(e_be));
                    chk("dm_wdata", dm_wdata, e_dwdata);
                end
            end
            if (dm_req) begin
                req_seen++;
                cap_be = dm_be;
                cap_dwdata = dm_wdata;
            end
            if (stallreq_mem) stall_seen++;
            if (e_done) done_wdata = wb_reg_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic st, input logic rq, input logic ex,
                           input logic wb, input logic dn, input logic dm);
        e_stall = st;
        e_req   = rq;
        e_excp  = ex;
        e_wb    = wb;
        e_done  = dn;
        e_dm    = dm;
    endtask

    // ack_at: REQ cycle (1-based) carrying dm_ack, 0 = never acked.
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr,
            input logic [31:0] rt, input logic [31:0] regw,
            input logic [4:0] rd, input logic we, input int ack_at,
            input logic [31:0] word, input bit stray);
        bit ld, st, mis, tmo;
        int nreq;
        ld  = op inside {LB, LH, LW, LBU, LHU};
        st  = op inside {SB, SH, SW};
        mis = ((op == LH || op == LHU || op == SH) && addr[0])
            || ((op == LW || op == SW) && addr[1:0] != 2'b00);
        mem_aluop = op;
        mem_mem_addr = addr;
        mem_rt_data = rt;
        mem_reg_wdata = regw;
        mem_reg_waddr = rd;
        mem_we = we;
        dm_ack = 1'b0;
        dm_rdata = 32'h0;
        req_seen = 0;
        stall_seen = 0;
        done_wdata = 32'h0;
        e_waddr = rd;
        e_addr = {addr[31:2], 2'b00};
        e_be = be_model(op, addr[1:0]);
        e_dwdata = wd_model(op, rt);
        e_st = st;
        chk_en = 1'b1;
        if (!(ld || st) || mis) begin
            e_we = mis ? 1'b0 : we;
            e_wdata = regw;
            set_exp(1'b0, 1'b0, mis, 1'b1, 1'b0, 1'b0);
            tick();
        end else begin
            tmo = (ack_at == 0);
            nreq = tmo ? TO : ack_at;
            set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            dm_ack = stray;
            dm_rdata = 32'h5A5A5A5A;
            tick();
            for (int k = 1; k <= nreq; k++) begin
                set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
                dm_ack = (k == ack_at);
                dm_rdata = (k == ack_at) ? word : 32'hC0FFEE00 + 32'(k);
                tick();
            end
            e_we = tmo ? 1'b0 : we;
            e_wdata = ld ? ld_model(op, addr, word) : regw;
            set_exp(1'b0, 1'b0, tmo, 1'b1, 1'b1, 1'b0);
            dm_ack = stray;
            dm_rdata = 32'h5A5A5A5A;
            tick();
        end
        dm_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        mem_aluop = 8'h00;
        mem_mem_addr = 32'h0;
        mem_rt_data = 32'h0;
        mem_reg_wdata = 32'h0000_1234;
        mem_reg_waddr = 5'd3;
        mem_we = 1'b1;
        dm_ack = 1'b0;
        dm_rdata = 32'h0;
        tick();
        e_waddr = 5'd3;
        e_we = 1'b1;
        e_wdata = 32'h0000_1234;
        set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        run_op(8'h11, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 5'd9, 1'b1, 0, 0, 0);
        run_op(8'h00, 32'h0, 32'h0, 32'h0000_0042, 5'd1, 1'b0, 0, 0, 0);

        run_op(LW, 32'h100, 32'h0, 32'h0, 5'd4, 1'b1, 1, 32'hDEADBEEF, 0);
        chk("lw_word", done_wdata, 32'hDEADBEEF);
        chk("lw_stall_cycles", 32'(stall_seen), 32'd2);

        run_op(LB, 32'h103, 32'h0, 32'h0, 5'd5, 1'b1, 1, 32'h80FF0011, 0);
        chk("lb_sext", done_wdata, 32'hFFFFFF80);
        run_op(LBU, 32'h103, 32'h0, 32'h0, 5'd6, 1'b1, 1, 32'h80FF0011, 0);
        chk("lbu_zext", done_wdata, 32'h00000080);
        run_op(LHU, 32'h102, 32'h0, 32'h0, 5'd7, 1'b1, 1, 32'h80FF0011, 0);
        chk("lhu_zext", done_wdata, 32'h000080FF);
        run_op(LH, 32'h102, 32'h0, 32'h0, 5'd8, 1'b0, 2, 32'h80FF0011, 1);
        run_op(LB, 32'h101, 32'h0, 32'h0, 5'd2, 1'b1, 3, 32'h12345678, 1);
        chk("lb_ack3", done_wdata, 32'h00000056);

        run_op(SH, 32'h202, 32'h1234ABCD, 32'h77, 5'd0, 1'b0, 1, 0, 0);
        chk("sh_be", 32'(cap_be), 32'h0000000C);
        chk("sh_wdata", cap_dwdata, 32'hABCDABCD);
        run_op(SB, 32'h201, 32'h000000A5, 32'h55, 5'd0, 1'b0, 2, 0, 0);
        run_op(SW, 32'h204, 32'h0BAD_F00D, 32'h66, 5'd10, 1'b1, 1, 0, 0);

        run_op(LW, 32'h101, 32'h0, 32'h99, 5'd11, 1'b1, 1, 32'h1, 0);
        chk("mis_req_cycles", 32'(req_seen), 32'd0);
        chk("mis_stall_cycles", 32'(stall_seen), 32'd0);
        run_op(SH, 32'h203, 32'h1, 32'h98, 5'd12, 1'b1, 1, 0, 0);
        run_op(LHU, 32'h101, 32'h0, 32'h97, 5'd13, 1'b1, 1, 32'h1, 0);

        run_op(LW, 32'h110, 32'h0, 32'h0, 5'd14, 1'b1, 0, 0, 0);
        chk("tmo_req_cycles", 32'(req_seen), 32'(TO));
        run_op(LW, 32'h114, 32'h0, 32'h0, 5'd15, 1'b1, 1, 32'h0F0F0F0F, 0);
        chk("after_tmo_word", done_wdata, 32'h0F0F0F0F);

        mem_aluop = LW;
        mem_mem_addr = 32'h300;
        mem_reg_waddr = 5'd16;
        mem_we = 1'b1;
        req_seen = 0;
        e_addr = 32'h300;
        e_st = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_aluop = 8'h00;
        mem_reg_wdata = 32'h1111_2222;
        mem_reg_waddr = 5'd17;
        dm_ack = 1'b1;
        dm_rdata = 32'hBAD0BAD0;
        e_waddr = 5'd17;
        e_we = 1'b1;
        e_wdata = 32'h1111_2222;
        set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        dm_ack = 1'b0;
        tick();
        chk("rst_req_cycles", 32'(req_seen), 32'd2);

        run_op(LW, 32'h300, 32'h0, 32'h0, 5'd18, 1'b1, 1, 32'h13579BDF, 0);
        chk("post_rst_word", done_wdata, 32'h13579BDF);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
